// File: rtl/instr_mem_server.sv
//------------------------------------------------------------------------------
// instr_mem_server
//
// Read-only instruction memory behind a fixed-latency fetch port. A request
// is latched when the server is idle or presenting a response. The array is
// then accessed for WAIT_STATES extra cycles, and the word is presented for
// exactly one cycle. The fetch stage is told to hold its PC (stall_f) while
// its request has not yet been answered.
//
// Optional feature macro: INSTR_BUF_EN
//   When defined, a one-entry buffer (tag, word, valid) remembers the last
//   successfully fetched word. A request that hits it is answered after a
//   single cycle, skipping the wait states. When undefined, every access
//   takes the full latency.
//
// Parameters
//   MEM_WORDS    number of 32-bit instruction words stored
//   WAIT_STATES  extra cycles per array access (0..15)
//   START_ADDR   byte address of word 0
//
// Ports
//   clock        single clock, all state changes on its rising edge
//   reset        synchronous, active-high
//   fetch_req    fetch stage requests the word at fetch_addr
//   fetch_addr   byte address of the requested instruction
//   instruction  returned word (zero outside a response or on error)
//   instr_valid  instruction is valid this cycle
//   stall_f      fetch stage must hold its PC
//   addr_err     latched request was misaligned or out of range
//   start_addr   constant START_ADDR, used as the PC reset value
//
// The array has no write port. Its image is placed there at elaboration by
// an initial block in the enclosing environment.
//------------------------------------------------------------------------------
module instr_mem_server #(
    parameter int          MEM_WORDS   = 1024,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] START_ADDR  = 32'h0040_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic        stall_f,
    output logic        addr_err,
    output logic [31:0] start_addr
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    logic [31:0] r_mem [MEM_WORDS];

    logic [1:0]  r_state;
    logic [3:0]  r_count;
    logic [31:0] r_reqAddr;

    logic [31:0] w_offset;
    logic [31:0] w_index;
    logic        w_err;
    logic [31:0] w_memWord;
    logic [31:0] w_word;
    logic        w_hit;

    // Index arithmetic is plain 32-bit unsigned. An address below START_ADDR
    // wraps to a huge index, so it is flagged explicitly as well as by the
    // range check; it can never alias into the array.
    assign w_offset  = r_reqAddr - START_ADDR;
    assign w_index   = w_offset >> 2;
    assign w_err     = (r_reqAddr[1:0] != 2'b00) || (r_reqAddr < START_ADDR)
                       || (w_index >= 32'(MEM_WORDS));
    assign w_memWord = r_mem[w_index[IDX_W-1:0]];

`ifdef INSTR_BUF_EN
    logic [31:0] r_bufTag;
    logic [31:0] r_bufWord;
    logic        r_bufValid;
    logic        r_fromBuf;
    logic [31:0] r_hitWord;
    logic        w_fill;
    logic        w_fwdHit;

    // The buffer is refreshed by every good response. A request for the
    // address being answered right now is a hit too, even though the entry
    // only takes that address on this same edge.
    assign w_fill   = (r_state == ST_RESP) && !w_err;
    assign w_fwdHit = w_fill && (r_reqAddr == fetch_addr);
    assign w_hit    = (r_bufValid && (r_bufTag == fetch_addr)) || w_fwdHit;

    // The hit word is copied aside at accept time. The entry itself may be
    // overwritten by the response that is leaving on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bufTag   <= '0;
            r_bufWord  <= '0;
            r_bufValid <= 1'b0;
            r_fromBuf  <= 1'b0;
            r_hitWord  <= '0;
        end else begin
            if (w_fill) begin
                r_bufTag   <= r_reqAddr;
                r_bufWord  <= w_memWord;
                r_bufValid <= 1'b1;
            end
            if (fetch_req && (r_state != ST_WAIT)) begin
                r_fromBuf <= w_hit;
                r_hitWord <= w_fwdHit ? w_memWord : r_bufWord;
            end
        end
    end

    assign w_word = r_fromBuf ? r_hitWord : w_memWord;
`else
    assign w_hit  = 1'b0;
    assign w_word = w_memWord;
`endif

    // Request sequencing. An accept latches the address and starts the
    // wait-state count. With no wait states, or on a buffer hit, it jumps
    // straight to the response. A response cycle may accept the next
    // request, which gives back-to-back throughput.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_reqAddr <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    if (fetch_req) begin
                        r_reqAddr <= fetch_addr;
                        if (w_hit || (WAIT_STATES == 0)) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_WAIT;
                            r_count <= WAIT_LOAD;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (r_count == 4'd0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Outputs are quiet outside the response cycle. An erroneous request is
    // answered with a NOP and the error flag.
    always_comb begin
        instr_valid = 1'b0;
        addr_err    = 1'b0;
        instruction = '0;
        if (r_state == ST_RESP) begin
            instr_valid = 1'b1;
            addr_err    = w_err;
            instruction = w_err ? 32'h0000_0000 : w_word;
        end
    end

    assign stall_f    = fetch_req && (r_state != ST_RESP);
    assign start_addr = START_ADDR;

endmodule

// File: tb/tb_instr_mem_server.sv
//------------------------------------------------------------------------------
// tb_instr_mem_server
//
// Two servers share one clock: dut0 with two wait states and dut1 with none.
// A cycle-level reference model predicts, for every cycle, which response
// (if any) each server presents. The model works from the request/latency
// rules: an answer W+1 cycles after the accept, or one cycle after the
// accept on a buffer hit when INSTR_BUF_EN is defined.
//------------------------------------------------------------------------------
module tb_instr_mem_server;

    localparam int          MEM_WORDS = 1024;
    localparam logic [31:0] START     = 32'h0040_0000;
    localparam int          W0        = 2;
    localparam int          W1        = 0;

    logic        clock;
    logic        reset;
    logic        reqIn  [2];
    logic [31:0] addrIn [2];

    logic [31:0] d0Instr, d1Instr, d0Start, d1Start;
    logic        d0Valid, d1Valid, d0Stall, d1Stall, d0Err, d1Err;

    logic [31:0] refMem [MEM_WORDS];

    int          cyc;
    int          pendCycle [2];
    logic [31:0] pendAddr  [2];
`ifdef INSTR_BUF_EN
    bit          bufValid  [2];
    logic [31:0] bufTag    [2];
`endif

    int testCount;
    int failCount;

    instr_mem_server #(.MEM_WORDS(MEM_WORDS), .WAIT_STATES(W0), .START_ADDR(START)) dut0 (
        .clock(clock), .reset(reset), .fetch_req(reqIn[0]), .fetch_addr(addrIn[0]),
        .instruction(d0Instr), .instr_valid(d0Valid), .stall_f(d0Stall),
        .addr_err(d0Err), .start_addr(d0Start)
    );

    instr_mem_server #(.MEM_WORDS(MEM_WORDS), .WAIT_STATES(W1), .START_ADDR(START)) dut1 (
        .clock(clock), .reset(reset), .fetch_req(reqIn[1]), .fetch_addr(addrIn[1]),
        .instruction(d1Instr), .instr_valid(d1Valid), .stall_f(d1Stall),
        .addr_err(d1Err), .start_addr(d1Start)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: address legality from the memory map, with wide
    // arithmetic so that nothing wraps.
    function automatic bit isErr(input logic [31:0] a);
        longint unsigned la;
        la = 64'(a);
        return (a[1:0] != 2'b00) || (la < 64'(START))
               || (la >= 64'(START) + 64'(4 * MEM_WORDS));
    endfunction

    function automatic bit expValid(input int d);
        return pendCycle[d] == cyc;
    endfunction

    function automatic bit expErr(input int d);
        return expValid(d) && isErr(pendAddr[d]);
    endfunction

    function automatic logic [31:0] expInstr(input int d);
        if (!expValid(d) || isErr(pendAddr[d])) return 32'h0;
        return refMem[int'((pendAddr[d] - START) >> 2)];
    endfunction

    function automatic bit expStall(input int d);
        return reqIn[d] && !expValid(d);
    endfunction

    function automatic logic [31:0] randAddr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0:       a = START + 32'(4 * $urandom_range(0, MEM_WORDS - 1)) + 32'($urandom_range(1, 3));
            1:       a = START - 32'(4 * $urandom_range(1, 8));
            2:       a = START + 32'(4 * MEM_WORDS) + 32'(4 * $urandom_range(0, 8));
            3:       a = $urandom() & 32'hFFFF_FFFC;
            4, 5:    a = START + 32'(4 * $urandom_range(0, MEM_WORDS - 1));
            default: a = START + 32'(4 * $urandom_range(0, 3));
        endcase
        return a;
    endfunction

    // One clock edge: the model consumes the inputs present at the edge,
    // then the bench returns on the falling edge to drive the next cycle.
    task automatic applyStimulus();
        int lat;
        @(posedge clock);
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                pendCycle[d] = -1;
`ifdef INSTR_BUF_EN
                bufValid[d] = 1'b0;
`endif
            end else begin
                if (pendCycle[d] == cyc) begin
`ifdef INSTR_BUF_EN
                    if (!isErr(pendAddr[d])) begin
                        bufValid[d] = 1'b1;
                        bufTag[d]   = pendAddr[d];
                    end
`endif
                    pendCycle[d] = -1;
                end
                if (reqIn[d] && pendCycle[d] < 0) begin
                    lat = ((d == 0) ? W0 : W1) + 1;
`ifdef INSTR_BUF_EN
                    if (bufValid[d] && bufTag[d] == addrIn[d]) lat = 1;
`endif
                    pendCycle[d] = cyc + lat;
                    pendAddr[d]  = addrIn[d];
                end
            end
        end
        cyc++;
        @(negedge clock);
    endtask

    task automatic applyReset();
        reset     = 1'b1;
        reqIn[0]  = 1'b0;
        reqIn[1]  = 1'b0;
        applyStimulus();
        reset     = 1'b0;
    endtask

    // Reset clears outputs, wins over a simultaneous request, and leaves
    // no response behind.
    task automatic test_reset();
        reset    = 1'b1;
        reqIn[0] = 1'b1;
        addrIn[0] = START;
        applyStimulus();
        applyStimulus();
        #1;
        testCount++;
        if ({d0Valid, d0Err, d0Instr, d1Valid, d1Err, d1Instr} !== 68'h0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs got v0=%b e0=%b i0=%h v1=%b e1=%b i1=%h expected all zero",
                     d0Valid, d0Err, d0Instr, d1Valid, d1Err, d1Instr);
        end
        testCount++;
        if (d0Start !== 32'h0040_0000 || d1Start !== 32'h0040_0000) begin
            failCount++;
            $display("[TB] FAIL start_addr got %h/%h expected 00400000", d0Start, d1Start);
        end
        reset    = 1'b0;
        reqIn[0] = 1'b0;
        for (int n = 0; n < 5; n++) begin
            #1;
            testCount++;
            if ({d0Valid, d0Err, d0Stall, d0Instr} !== {expValid(0), expErr(0), expStall(0), expInstr(0)}) begin
                failCount++;
                $display("[TB] FAIL reset_quiet cyc=%0d got v=%b e=%b s=%b i=%h expected v=%b e=%b s=%b i=%h",
                         cyc, d0Valid, d0Err, d0Stall, d0Instr, expValid(0), expErr(0), expStall(0), expInstr(0));
            end
            applyStimulus();
        end
    endtask

    // A single fetch of word 0: three stalled cycles, then the word.
    task automatic test_single_fetch();
        int          lat;
        int          stalls;
        logic [31:0] got;
        applyReset();
        lat       = -1;
        stalls    = 0;
        got       = '0;
        reqIn[0]  = 1'b1;
        addrIn[0] = START;
        for (int n = 0; n < 8; n++) begin
            #1;
            testCount++;
            if ({d0Valid, d0Err, d0Stall, d0Instr} !== {expValid(0), expErr(0), expStall(0), expInstr(0)}) begin
                failCount++;
                $display("[TB] FAIL single_fetch cyc=%0d got v=%b e=%b s=%b i=%h expected v=%b e=%b s=%b i=%h",
                         cyc, d0Valid, d0Err, d0Stall, d0Instr, expValid(0), expErr(0), expStall(0), expInstr(0));
            end
            if (d0Stall) stalls++;
            if (d0Valid && lat < 0) begin
                lat      = n;
                got      = d0Instr;
                reqIn[0] = 1'b0;
            end
            applyStimulus();
        end
        testCount++;
        if (lat != 3 || got !== 32'h2008_0005 || stalls != 3) begin
            failCount++;
            $display("[TB] FAIL single_latency got lat=%0d word=%h stalls=%0d expected lat=3 word=20080005 stalls=3",
                     lat, got, stalls);
        end
    endtask

    // Continuous requests for three consecutive words: one answer every
    // three cycles with no gaps.
    task automatic test_back_to_back();
        int k;
        int seen[$];
        applyReset();
        k = 0;
        for (int n = 0; n < 12; n++) begin
            if (expValid(0)) k++;
            reqIn[0]  = (k < 3);
            addrIn[0] = START + 32'(4 * k);
            #1;
            testCount++;
            if ({d0Valid, d0Err, d0Stall, d0Instr} !== {expValid(0), expErr(0), expStall(0), expInstr(0)}) begin
                failCount++;
                $display("[TB] FAIL back_to_back cyc=%0d got v=%b e=%b s=%b i=%h expected v=%b e=%b s=%b i=%h",
                         cyc, d0Valid, d0Err, d0Stall, d0Instr, expValid(0), expErr(0), expStall(0), expInstr(0));
            end
            if (d0Valid) seen.push_back(n);
            applyStimulus();
        end
        testCount++;
        if (seen.size() != 3 || seen[0] != 3 || seen[1] != 6 || seen[2] != 9) begin
            failCount++;
            $display("[TB] FAIL b2b_spacing got %0d valids (first at %0d) expected valids at 3,6,9",
                     seen.size(), (seen.size() > 0) ? seen[0] : -1);
        end
    endtask

    // Misaligned, below-base and past-end requests answer NOP with addr_err.
    task automatic test_addr_error();
        logic [31:0] errAddrs [3];
        logic [31:0] gotInstr;
        logic        gotErr;
        bit          done;
        errAddrs[0] = 32'h0040_0002;
        errAddrs[1] = 32'h003F_FFFC;
        errAddrs[2] = START + 32'(4 * MEM_WORDS);
        applyReset();
        for (int a = 0; a < 3; a++) begin
            done      = 1'b0;
            gotErr    = 1'b0;
            gotInstr  = 32'hDEAD_BEEF;
            reqIn[0]  = 1'b1;
            addrIn[0] = errAddrs[a];
            for (int n = 0; n < 8 && !done; n++) begin
                #1;
                testCount++;
                if ({d0Valid, d0Err, d0Stall, d0Instr} !== {expValid(0), expErr(0), expStall(0), expInstr(0)}) begin
                    failCount++;
                    $display("[TB] FAIL addr_error cyc=%0d got v=%b e=%b s=%b i=%h expected v=%b e=%b s=%b i=%h",
                             cyc, d0Valid, d0Err, d0Stall, d0Instr, expValid(0), expErr(0), expStall(0), expInstr(0));
                end
                if (d0Valid) begin
                    done     = 1'b1;
                    gotErr   = d0Err;
                    gotInstr = d0Instr;
                    reqIn[0] = 1'b0;
                end
                applyStimulus();
            end
            testCount++;
            if (!done || gotErr !== 1'b1 || gotInstr !== 32'h0) begin
                failCount++;
                $display("[TB] FAIL addr_error_resp addr=%h got seen=%b err=%b instr=%h expected seen=1 err=1 instr=00000000",
                         errAddrs[a], done, gotErr, gotInstr);
            end
        end
    endtask

    // Reset in the middle of the wait states drops that access; a new
    // request afterwards takes the full latency.
    task automatic test_reset_in_wait();
        int lat;
        applyReset();
        reqIn[0]  = 1'b1;
        addrIn[0] = START + 32'h20;
        applyStimulus();
        #1;
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        lat   = -1;
        for (int n = 0; n < 8; n++) begin
            #1;
            testCount++;
            if ({d0Valid, d0Err, d0Stall, d0Instr} !== {expValid(0), expErr(0), expStall(0), expInstr(0)}) begin
                failCount++;
                $display("[TB] FAIL reset_in_wait cyc=%0d got v=%b e=%b s=%b i=%h expected v=%b e=%b s=%b i=%h",
                         cyc, d0Valid, d0Err, d0Stall, d0Instr, expValid(0), expErr(0), expStall(0), expInstr(0));
            end
            if (d0Valid && lat < 0) begin
                lat      = n;
                reqIn[0] = 1'b0;
            end
            applyStimulus();
        end
        testCount++;
        if (lat != 3) begin
            failCount++;
            $display("[TB] FAIL reset_in_wait_latency got %0d expected 3", lat);
        end
    endtask

    // The same address requested twice in a row: with the buffer, the
    // repeat is answered one cycle after the first response.
    task automatic test_buffer_repeat();
        int          v1, v2, wantGap;
        logic [31:0] w1, w2;
        applyReset();
        v1 = -1;
        v2 = -1;
        w1 = '0;
        w2 = '1;
`ifdef INSTR_BUF_EN
        wantGap = 1;
`else
        wantGap = 3;
`endif
        reqIn[0]  = 1'b1;
        addrIn[0] = START + 32'h10;
        for (int n = 0; n < 12; n++) begin
            #1;
            testCount++;
            if ({d0Valid, d0Err, d0Stall, d0Instr} !== {expValid(0), expErr(0), expStall(0), expInstr(0)}) begin
                failCount++;
                $display("[TB] FAIL buffer_repeat cyc=%0d got v=%b e=%b s=%b i=%h expected v=%b e=%b s=%b i=%h",
                         cyc, d0Valid, d0Err, d0Stall, d0Instr, expValid(0), expErr(0), expStall(0), expInstr(0));
            end
            if (d0Valid) begin
                if (v1 < 0) begin
                    v1 = n;
                    w1 = d0Instr;
                end else if (v2 < 0) begin
                    v2       = n;
                    w2       = d0Instr;
                    reqIn[0] = 1'b0;
                end
            end
            applyStimulus();
        end
        testCount++;
        if (v1 != 3 || v2 - v1 != wantGap || w1 !== w2 || w1 !== refMem[4]) begin
            failCount++;
            $display("[TB] FAIL buffer_latency got first=%0d gap=%0d w1=%h w2=%h expected first=3 gap=%0d word=%h",
                     v1, v2 - v1, w1, w2, wantGap, refMem[4]);
        end
    endtask

    // No wait states: a new word every cycle and no stall once running.
    task automatic test_zero_wait();
        int k, vCnt, sCnt;
        applyReset();
        k    = 0;
        vCnt = 0;
        sCnt = 0;
        for (int n = 0; n < 10; n++) begin
            if (expValid(1)) k++;
            reqIn[1]  = (k < 8);
            addrIn[1] = START + 32'(4 * k);
            #1;
            testCount++;
            if ({d1Valid, d1Err, d1Stall, d1Instr} !== {expValid(1), expErr(1), expStall(1), expInstr(1)}) begin
                failCount++;
                $display("[TB] FAIL zero_wait cyc=%0d got v=%b e=%b s=%b i=%h expected v=%b e=%b s=%b i=%h",
                         cyc, d1Valid, d1Err, d1Stall, d1Instr, expValid(1), expErr(1), expStall(1), expInstr(1));
            end
            if (n >= 1 && n <= 8) begin
                if (d1Valid) vCnt++;
                if (d1Stall) sCnt++;
            end
            applyStimulus();
        end
        testCount++;
        if (vCnt != 8 || sCnt != 0) begin
            failCount++;
            $display("[TB] FAIL zero_wait_rate got valids=%0d stalls=%0d expected valids=8 stalls=0", vCnt, sCnt);
        end
    endtask

    // Random traffic on both servers, including errors, repeats and resets,
    // with the address held while the requester is stalled.
    task automatic test_random();
        applyReset();
        for (int n = 0; n < 600; n++) begin
            for (int d = 0; d < 2; d++) begin
                if (!(reqIn[d] && !expValid(d))) begin
                    reqIn[d]  = ($urandom_range(0, 3) != 0);
                    addrIn[d] = randAddr();
                end
            end
            reset = ($urandom_range(0, 49) == 0);
            #1;
            testCount++;
            if ({d0Valid, d0Err, d0Stall, d0Instr} !== {expValid(0), expErr(0), expStall(0), expInstr(0)}) begin
                failCount++;
                $display("[TB] FAIL random_ws2 cyc=%0d got v=%b e=%b s=%b i=%h expected v=%b e=%b s=%b i=%h",
                         cyc, d0Valid, d0Err, d0Stall, d0Instr, expValid(0), expErr(0), expStall(0), expInstr(0));
            end
            testCount++;
            if ({d1Valid, d1Err, d1Stall, d1Instr} !== {expValid(1), expErr(1), expStall(1), expInstr(1)}) begin
                failCount++;
                $display("[TB] FAIL random_ws0 cyc=%0d got v=%b e=%b s=%b i=%h expected v=%b e=%b s=%b i=%h",
                         cyc, d1Valid, d1Err, d1Stall, d1Instr, expValid(1), expErr(1), expStall(1), expInstr(1));
            end
            applyStimulus();
        end
        reset    = 1'b0;
        reqIn[0] = 1'b0;
        reqIn[1] = 1'b0;
    endtask

    initial begin
        testCount    = 0;
        failCount    = 0;
        cyc          = 0;
        pendCycle[0] = -1;
        pendCycle[1] = -1;
        pendAddr[0]  = '0;
        pendAddr[1]  = '0;
`ifdef INSTR_BUF_EN
        bufValid[0]  = 1'b0;
        bufValid[1]  = 1'b0;
        bufTag[0]    = '0;
        bufTag[1]    = '0;
`endif
        reset     = 1'b1;
        reqIn[0]  = 1'b0;
        reqIn[1]  = 1'b0;
        addrIn[0] = '0;
        addrIn[1] = '0;
        for (int i = 0; i < MEM_WORDS; i++) refMem[i] = $urandom();
        refMem[0] = 32'h2008_0005;
        for (int i = 0; i < MEM_WORDS; i++) begin
            dut0.r_mem[i] = refMem[i];
            dut1.r_mem[i] = refMem[i];
        end

        test_reset();
        test_single_fetch();
        test_back_to_back();
        test_addr_error();
        test_reset_in_wait();
        test_buffer_repeat();
        test_zero_wait();
        test_random();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/instr_mem_server.md
INSTR_MEM_SERVER -- requirements
Module: instr_mem_server

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024: instruction words stored.
REQ-002 SHALL have parameter WAIT_STATES, default 2: extra cycles per array access, legal range 0..15.
REQ-003 SHALL have parameter START_ADDR, default 32'h0040_0000: byte address of word 0.
REQ-004 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-006 SHALL have port fetch_req, input, 1: fetch stage requests the word at fetch_addr.
REQ-007 SHALL have port fetch_addr, input, 32: byte address of the requested instruction.
REQ-008 SHALL have port instruction, output, 32: returned instruction word.
REQ-009 SHALL have port instr_valid, output, 1: instruction is valid this cycle.
REQ-010 SHALL have port stall_f, output, 1: fetch stage holds its PC.
REQ-011 SHALL have port addr_err, output, 1: the latched request was misaligned or out of range.
REQ-012 SHALL have port start_addr, output, 32: constant START_ADDR, used as the PC reset value.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-014 SHALL accept a request in IDLE or RESP when fetch_req=1 at a rising edge, latching fetch_addr into req_addr.
REQ-015 SHALL go from an accept to WAIT when WAIT_STATES>0, loading the wait counter with WAIT_STATES-1; otherwise it SHALL go directly to RESP.
REQ-016 SHALL decrement the counter in WAIT and enter RESP on the edge where the counter equals 0.
REQ-017 SHALL drive instr_valid=1 only in RESP, with instruction = mem[(req_addr-START_ADDR)>>2].
REQ-018 SHALL, in RESP, accept a new request if fetch_req=1 (back-to-back), otherwise return to IDLE.
REQ-019 SHALL give a latency of exactly WAIT_STATES+1 cycles from the accept edge to instr_valid, with one instruction per WAIT_STATES+1 cycles under continuous requests.
REQ-020 SHALL compute stall_f combinationally as fetch_req AND (state != RESP).
REQ-021 SHALL require fetch_addr to be held stable while stall_f=1 (protocol rule); the block uses req_addr only.
REQ-022 SHALL treat req_addr[1:0]!=0, req_addr<START_ADDR, or index>=MEM_WORDS as an error: instruction=32'h0000_0000 (NOP) and addr_err=1 during RESP.
REQ-023 SHALL make the index arithmetic 32-bit unsigned; subtraction wrap below START_ADDR SHALL NOT alias into the array.
REQ-024 SHALL drive instruction=0 and addr_err=0 outside RESP.
REQ-025 SHALL make the contents of mem loadable at elaboration through an initial block; the array SHALL be read-only at runtime.

Reset
REQ-026 SHALL, on reset=1 at a rising edge, set state=IDLE, counter=0, req_addr=0, and buffer invalid.
REQ-027 SHALL have instr_valid=0, instruction=0, and addr_err=0 in the cycle after reset.
REQ-028 SHALL let reset abandon an in-flight access, with no response issued for it.
REQ-029 SHALL let reset take priority over a simultaneous fetch_req.

Configuration
REQ-030 SHALL, with INSTR_BUF_EN defined, include a one-entry buffer (tag, word, valid), filled on every non-error RESP.
REQ-031 SHALL, with INSTR_BUF_EN defined, send an accept whose address equals a valid tag directly to RESP (latency 1), bypassing WAIT.
REQ-032 SHALL, without INSTR_BUF_EN, omit the buffer and give every access the full latency.

Verification
REQ-033 SHALL cover this scenario: WAIT_STATES=2, mem[0]=32'h2008_0005, request 32'h0040_0000 at edge 0 -> stall_f=1 for cycles 0-2, instr_valid=1 with that word at cycle 3.
REQ-034 SHALL cover this scenario: fetch_req held high, addresses 32'h0040_0000/04/08 -> one valid every 3 cycles, no gaps or duplicates.
REQ-035 SHALL cover this scenario: request 32'h0040_0002, then 32'h003F_FFFC -> instruction=0 and addr_err=1 in RESP for each.
REQ-036 SHALL cover this scenario: reset asserted during WAIT -> IDLE next cycle, instr_valid stays 0, and a new request has full latency.
REQ-037 SHALL cover this scenario: with INSTR_BUF_EN, repeat 32'h0040_0010 back-to-back -> first latency 3, second latency 1 with the identical word.
REQ-038 SHALL cover this scenario: WAIT_STATES=0 with continuous requests -> instr_valid=1 every cycle and stall_f=0 after the first cycle.
